// File: rtl/pi_controller.sv
// Pipelined PI controller: rounds a wide sensor sample, forms kp*err + integrator with
// anti-windup, then scales by >>>SHIFT and clamps to a signed DATA_W actuator command.
module pi_controller #(
    parameter int SENSOR_W = 12,
    parameter int DATA_W   = 8,
    parameter int GAIN_W   = 8,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_valid,
    input  logic [SENSOR_W-1:0]        sensor_reading,
    input  logic [DATA_W-1:0]          setpoint,
    input  logic [GAIN_W-1:0]          kp,
    input  logic [GAIN_W-1:0]          ki,
    input  logic                       integ_clear,
    output logic                       out_valid,
    output logic signed [DATA_W-1:0]   output_setpoint,
    output logic                       saturated,
    output logic signed [ACC_W-1:0]    integ_state
);
    localparam int ERR_W  = DATA_W + 1;
    localparam int PROD_W = ERR_W + GAIN_W + 1;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] round_sample(input logic [SENSOR_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = x[SENSOR_W-1 -: DATA_W];
        if (x[SENSOR_W-DATA_W-1] && (r != {DATA_W{1'b1}}))
            r = r + DATA_W'(1);
        return r;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] x);
        if (x > ACC_MAX)
            return ACC_MAX[ACC_W-1:0];
        else if (x < ACC_MIN)
            return ACC_MIN[ACC_W-1:0];
        return x[ACC_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [SUM_W-1:0] x);
        if (x > OUT_MAX)
            return OUT_MAX[DATA_W-1:0];
        else if (x < OUT_MIN)
            return OUT_MIN[DATA_W-1:0];
        return x[DATA_W-1:0];
    endfunction

    logic                     vld_p1, vld_p2, vld_p3;
    logic [DATA_W-1:0]        r_p1, sp_p1;
    logic [GAIN_W-1:0]        kp_p1, ki_p1, kp_p2, ki_p2;
    logic signed [ERR_W-1:0]  err_p2;
    logic signed [PROD_W-1:0] p_c, i_c, p_p3;
    logic signed [ACC_W-1:0]  integ, cand_c, integ_new_c, integ_p3;
    logic signed [SUM_W-1:0]  sum_c, chk_c, hsum_c, s_c;
    logic                     i_pos_c, i_neg_c, hold_c, hold_p3, clamp_c;
    logic signed [DATA_W-1:0] out_c;

    always_comb begin
        p_c = $signed({{(PROD_W-ERR_W){err_p2[ERR_W-1]}}, err_p2})
            * $signed({{(PROD_W-GAIN_W){1'b0}}, kp_p2});
        i_c = $signed({{(PROD_W-ERR_W){err_p2[ERR_W-1]}}, err_p2})
            * $signed({{(PROD_W-GAIN_W){1'b0}}, ki_p2});
        sum_c  = $signed({integ[ACC_W-1], integ})
               + $signed({{(SUM_W-PROD_W){i_c[PROD_W-1]}}, i_c});
        cand_c = sat_acc(sum_c);
        chk_c  = $signed({{(SUM_W-PROD_W){p_c[PROD_W-1]}}, p_c})
               + $signed({cand_c[ACC_W-1], cand_c});
        hsum_c = chk_c >>> SHIFT;
        // Freeze the integrator only while it would push further into the rail it is on
        i_pos_c = !i_c[PROD_W-1] && (i_c != '0);
        i_neg_c = i_c[PROD_W-1];
        hold_c  = (i_pos_c && (hsum_c > OUT_MAX)) || (i_neg_c && (hsum_c < OUT_MIN));
        if (integ_clear)
            integ_new_c = '0;
        else if (hold_c)
            integ_new_c = integ;
        else
            integ_new_c = cand_c;
        s_c = ($signed({{(SUM_W-PROD_W){p_p3[PROD_W-1]}}, p_p3})
             + $signed({integ_p3[ACC_W-1], integ_p3})) >>> SHIFT;
        clamp_c = (s_c > OUT_MAX) || (s_c < OUT_MIN);
        out_c   = sat_out(s_c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1          <= 1'b0;
            vld_p2          <= 1'b0;
            vld_p3          <= 1'b0;
            out_valid       <= 1'b0;
            r_p1            <= '0;
            sp_p1           <= '0;
            kp_p1           <= '0;
            ki_p1           <= '0;
            err_p2          <= '0;
            kp_p2           <= '0;
            ki_p2           <= '0;
            integ           <= '0;
            p_p3            <= '0;
            integ_p3        <= '0;
            hold_p3         <= 1'b0;
            output_setpoint <= '0;
            saturated       <= 1'b0;
            integ_state     <= '0;
        end else begin
            vld_p1    <= sample_valid;
            vld_p2    <= vld_p1;
            vld_p3    <= vld_p2;
            out_valid <= vld_p3;
            // S1: round sensor to DATA_W
            if (sample_valid) begin
                r_p1  <= round_sample(sensor_reading);
                sp_p1 <= setpoint;
                kp_p1 <= kp;
                ki_p1 <= ki;
            end
            // S2: error
            if (vld_p1) begin
                err_p2 <= $signed({1'b0, sp_p1}) - $signed({1'b0, r_p1});
                kp_p2  <= kp_p1;
                ki_p2  <= ki_p1;
            end
            // S3: terms and integrator update; clear wins over any update
            if (integ_clear)
                integ <= '0;
            else if (vld_p2 && !hold_c)
                integ <= cand_c;
            if (vld_p2) begin
                p_p3     <= p_c;
                integ_p3 <= integ_new_c;
                hold_p3  <= hold_c;
            end
            // S4: scale and clamp
            if (vld_p3) begin
                output_setpoint <= out_c;
                saturated       <= clamp_c || hold_p3;
                integ_state     <= integ_p3;
            end
        end
    end
endmodule

// File: tb/tb_pi_controller.sv
// Bench for pi_controller: table of hand-derived vectors plus corner-case sequences,
// checked through a scoreboard queue when out_valid appears.
module tb_pi_controller;
    logic               clk = 1'b0;
    logic               reset_n;
    logic               sample_valid;
    logic [11:0]        sensor_reading;
    logic [7:0]         setpoint;
    logic [7:0]         kp;
    logic [7:0]         ki;
    logic               integ_clear;
    logic               out_valid;
    logic signed [7:0]  output_setpoint;
    logic               saturated;
    logic signed [23:0] integ_state;

    pi_controller #(.SENSOR_W(12), .DATA_W(8), .GAIN_W(8), .ACC_W(24), .SHIFT(10)) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sensor_reading(sensor_reading), .setpoint(setpoint), .kp(kp), .ki(ki),
        .integ_clear(integ_clear), .out_valid(out_valid), .output_setpoint(output_setpoint),
        .saturated(saturated), .integ_state(integ_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] sensor;
        logic [7:0]  sp;
        logic [7:0]  kp;
        logic [7:0]  ki;
        logic        clr;
        int          exp_out;
        logic        exp_sat;
        int          exp_integ;
    } vec_t;

    typedef struct {
        int   out;
        logic sat;
        int   integ;
        int   cyc;
        int   id;
    } exp_t;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   next_id = 0;
    vec_t tbl[13];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int id, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (scb.size() == 0) begin
                check("spurious_out_valid", -1, 1, 0);
            end else begin
                exp_t e;
                e = scb.pop_front();
                check("output_setpoint", e.id, longint'(output_setpoint), e.out);
                check("saturated", e.id, saturated, e.sat);
                check("integ_state", e.id, longint'(integ_state), e.integ);
                check("latency", e.id, cyc - e.cyc, 4);
            end
        end
    end

    task automatic drive(input logic [11:0] s, input logic [7:0] sp_v, input logic [7:0] kp_v,
                         input logic [7:0] ki_v, input int eo, input logic es, input int ei);
        exp_t e;
        @(posedge clk); #1;
        sensor_reading = s;
        setpoint       = sp_v;
        kp             = kp_v;
        ki             = ki_v;
        sample_valid   = 1'b1;
        e.out = eo; e.sat = es; e.integ = ei; e.cyc = cyc; e.id = next_id++;
        scb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && scb.size() != 0; k++) @(posedge clk);
        check("drain_pending", next_id, scb.size(), 0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 integ_clear = 1'b1;
        @(posedge clk); #1 integ_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{12'h320, 8'd100, 8'd128, 8'd0,   1'b0,    6, 1'b0,      0};
        tbl[1]  = '{12'h328, 8'd51,  8'd255, 8'd0,   1'b0,    0, 1'b0,      0};
        tbl[2]  = '{12'hFF8, 8'd255, 8'd255, 8'd0,   1'b0,    0, 1'b0,      0};
        tbl[3]  = '{12'h000, 8'd0,   8'd255, 8'd0,   1'b0,    0, 1'b0,      0};
        tbl[4]  = '{12'hC80, 8'd0,   8'd255, 8'd0,   1'b0,  -50, 1'b0,      0};
        tbl[5]  = '{12'hFFF, 8'd0,   8'd255, 8'd0,   1'b0,  -64, 1'b0,      0};
        tbl[6]  = '{12'hFFF, 8'd0,   8'd255, 8'd255, 1'b0, -128, 1'b0, -65025};
        tbl[7]  = '{12'hFFF, 8'd0,   8'd255, 8'd255, 1'b0, -128, 1'b1, -65025};
        tbl[8]  = '{12'h000, 8'd255, 8'd0,   8'd255, 1'b1,   63, 1'b0,  65025};
        tbl[9]  = '{12'h000, 8'd255, 8'd0,   8'd255, 1'b0,  127, 1'b0, 130050};
        tbl[10] = '{12'h000, 8'd255, 8'd0,   8'd255, 1'b0,  127, 1'b1, 130050};
        tbl[11] = '{12'h000, 8'd255, 8'd255, 8'd0,   1'b0,  127, 1'b1, 130050};
        tbl[12] = '{12'hFFF, 8'd0,   8'd255, 8'd0,   1'b0,   63, 1'b0, 130050};

        reset_n = 1'b0; sample_valid = 1'b0; sensor_reading = '0; setpoint = '0;
        kp = '0; ki = '0; integ_clear = 1'b0;

        // Reset and idle
        #1;
        check("rst_out_valid", 0, out_valid, 0);
        check("rst_output", 0, longint'(output_setpoint), 0);
        check("rst_saturated", 0, saturated, 0);
        check("rst_integ", 0, longint'(integ_state), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("idle_out_valid", 0, out_valid, 0);
        check("idle_integ", 0, longint'(integ_state), 0);

        // Table vectors, back-to-back within each group
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].clr) begin
                idle();
                drain();
                pulse_clear();
            end
            drive(tbl[i].sensor, tbl[i].sp, tbl[i].kp, tbl[i].ki,
                  tbl[i].exp_out, tbl[i].exp_sat, tbl[i].exp_integ);
        end
        idle();
        drain();

        // Three back-to-back samples into the positive rail
        pulse_clear();
        drive(12'h000, 8'd255, 8'd255, 8'd255, 127, 1'b0, 65025);
        drive(12'h000, 8'd255, 8'd255, 8'd255, 127, 1'b1, 65025);
        drive(12'h000, 8'd255, 8'd255, 8'd255, 127, 1'b1, 65025);
        idle();
        drain();

        // Clear after windup, zero gains
        pulse_clear();
        drive(12'h320, 8'd50, 8'd0, 8'd0, 0, 1'b0, 0);
        idle();
        drain();

        // Clear coinciding with this sample's integrator update wins
        drive(12'h000, 8'd255, 8'd0, 8'd255, 0, 1'b0, 0);
        idle();
        #0 integ_clear = 1'b0;
        @(posedge clk); #1 integ_clear = 1'b1;
        @(posedge clk); #1 integ_clear = 1'b0;
        drive(12'h320, 8'd50, 8'd0, 8'd0, 0, 1'b0, 0);
        idle();
        drain();

        // Reset with three samples in flight
        drive(12'h000, 8'd255, 8'd0, 8'd255, 0, 1'b0, 0);
        drive(12'h000, 8'd255, 8'd0, 8'd255, 0, 1'b0, 0);
        drive(12'h000, 8'd255, 8'd0, 8'd255, 0, 1'b0, 0);
        @(posedge clk); #1 sample_valid = 1'b0;
        #1 reset_n = 1'b0;
        scb.delete();
        #1;
        check("midrst_out_valid", 0, out_valid, 0);
        check("midrst_integ", 0, longint'(integ_state), 0);
        check("midrst_output", 0, longint'(output_setpoint), 0);
        check("midrst_saturated", 0, saturated, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("postrst_out_valid", 0, out_valid, 0);
        drive(12'h320, 8'd100, 8'd128, 8'd0, 6, 1'b0, 0);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
